// File: rtl/tetris_pkg.sv
// Shared board geometry, row types and the line-clear engine state encoding.
// Imported by the line-clear engine and by the game control FSM (debug display).
package tetris_pkg;

  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned ROW_AW     = 5;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned TOTAL_W    = 16;

  typedef logic [BOARD_COLS-1:0] row_t;
  typedef logic [ROW_AW-1:0]     row_addr_t;

  typedef enum logic [2:0] {
    CL_IDLE,
    CL_SCAN,
    CL_SCAN_LAST,
    CL_COPY_RD,
    CL_COPY_WR,
    CL_FILL,
    CL_DONE
  } clearline_state_e;

endpackage

// File: rtl/clearline_engine.sv
// Line-clear responder: scans the board for full rows on CLEARLINECHECK and
// compacts the board (drop full rows, zero-fill the top) on CLEARLINEACT.
// Ports:
//   Clk, RESET (async, active-low)
//   CLEARLINECHECK, CLEARLINEACT : 1-cycle start strobes from the game FSM
//   rd_addr / rd_data            : board RAM read port, 1-cycle read latency
//   wr_en / wr_addr / wr_data    : board RAM write port
//   clearline, clearlineval      : result of the last scan (level)
//   done                         : 1-cycle pulse at the end of a scan or compaction
//   busy                         : high whenever the engine is not idle
//   lines_total                  : saturating count of cleared rows since reset
module clearline_engine
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS = BOARD_ROWS,
  parameter int unsigned COLS = BOARD_COLS
) (
  input  logic                Clk,
  input  logic                RESET,
  input  logic                CLEARLINECHECK,
  input  logic                CLEARLINEACT,
  output logic [ROW_AW-1:0]   rd_addr,
  input  logic [COLS-1:0]     rd_data,
  output logic                wr_en,
  output logic [ROW_AW-1:0]   wr_addr,
  output logic [COLS-1:0]     wr_data,
  output logic                clearline,
  output logic [CNT_W-1:0]    clearlineval,
  output logic                done,
  output logic                busy,
  output logic [TOTAL_W-1:0]  lines_total
);

  localparam row_addr_t LAST_ROW = row_addr_t'(ROWS - 1);

  clearline_state_e   state, state_d;
  row_addr_t          ptr, ptr_d;
  row_addr_t          src, src_d;
  row_addr_t          dst, dst_d;
  logic [ROWS-1:0]    full_mask, full_mask_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               clearline_d;
  logic [CNT_W-1:0]   clearlineval_d;
  logic [TOTAL_W-1:0] lines_total_d;

  // Row-full detect on the row returned for the previously issued address
  logic               row_is_full;
  row_addr_t          cap_idx;
  logic [TOTAL_W:0]   total_sum;

  assign row_is_full = &rd_data;
  assign total_sum   = {1'b0, lines_total} + (TOTAL_W + 1)'(clearlineval);

  // State and datapath registers
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state        <= CL_IDLE;
      ptr          <= '0;
      src          <= '0;
      dst          <= '0;
      full_mask    <= '0;
      cnt          <= '0;
      clearline    <= 1'b0;
      clearlineval <= '0;
      lines_total  <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      src          <= src_d;
      dst          <= dst_d;
      full_mask    <= full_mask_d;
      cnt          <= cnt_d;
      clearline    <= clearline_d;
      clearlineval <= clearlineval_d;
      lines_total  <= lines_total_d;
      done         <= (state_d == CL_DONE);
      busy         <= (state_d != CL_IDLE);
    end
  end

  // Next-state, datapath updates and RAM port drive.
  // RAM port signals are decoded from the current state: write data is the
  // read data returned in COPY_WR, so it cannot be delayed by a register.
  always_comb begin
    state_d        = state;
    ptr_d          = ptr;
    src_d          = src;
    dst_d          = dst;
    full_mask_d    = full_mask;
    cnt_d          = cnt;
    clearline_d    = clearline;
    clearlineval_d = clearlineval;
    lines_total_d  = lines_total;
    cap_idx        = ptr - row_addr_t'(1);
    rd_addr        = '0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;

    unique case (state)
      CL_IDLE: begin
        // Check has priority over act when both strobe together
        if (CLEARLINECHECK) begin
          state_d = CL_SCAN;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (CLEARLINEACT) begin
          if (clearlineval != '0) begin
            state_d = CL_COPY_RD;
            src_d   = LAST_ROW;
            dst_d   = LAST_ROW;
          end else begin
            // Nothing to clear: finish immediately with no RAM writes
            state_d        = CL_DONE;
            full_mask_d    = '0;
            clearline_d    = 1'b0;
            clearlineval_d = '0;
          end
        end
      end

      CL_SCAN: begin
        rd_addr = ptr;
        ptr_d   = ptr + row_addr_t'(1);
        if (ptr != '0) begin
          full_mask_d[cap_idx] = row_is_full;
          if (row_is_full) cnt_d = cnt + CNT_W'(1);
        end
        if (ptr == LAST_ROW) state_d = CL_SCAN_LAST;
      end

      CL_SCAN_LAST: begin
        // Capture the last row and publish the results on entry to DONE
        full_mask_d[LAST_ROW] = row_is_full;
        if (row_is_full) cnt_d = cnt + CNT_W'(1);
        clearline_d    = (cnt_d != '0);
        clearlineval_d = cnt_d;
        state_d        = CL_DONE;
      end

      CL_COPY_RD: begin
        if (full_mask[src]) begin
          // Skip a full row; zero is tested before decrementing so src never wraps
          if (src == '0) state_d = CL_FILL;
          else           src_d   = src - row_addr_t'(1);
        end else begin
          rd_addr = src;
          state_d = CL_COPY_WR;
        end
      end

      CL_COPY_WR: begin
        wr_en   = 1'b1;
        wr_addr = dst;
        wr_data = rd_data;
        dst_d   = dst - row_addr_t'(1);
        if (src == '0) begin
          state_d = CL_FILL;
        end else begin
          src_d   = src - row_addr_t'(1);
          state_d = CL_COPY_RD;
        end
      end

      CL_FILL: begin
        wr_en   = 1'b1;
        wr_addr = dst;
        wr_data = '0;
        if (dst == '0) begin
          state_d        = CL_DONE;
          lines_total_d  = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
          full_mask_d    = '0;
          clearline_d    = 1'b0;
          clearlineval_d = '0;
        end else begin
          dst_d = dst - row_addr_t'(1);
        end
      end

      CL_DONE: begin
        state_d = CL_IDLE;
      end

      default: begin
        state_d = CL_IDLE;
      end
    endcase
  end

endmodule
